piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out front end that feeds the serial sequence-detector stage one bit per clock on `dout`.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out with no gap between back-to-back words.
- Marks bit validity and frame boundaries so downstream logic can align its events to word positions.

Parameters:
- WIDTH, 8, word width in bits; legal values are WIDTH >= 2.
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
- IDLE_BIT, 0, value driven on `dout` when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  parallel word to serialize
- in_valid  input  1  in_data holds a valid word
- in_ready  output  1  block accepts a word this cycle; a transfer occurs when in_valid & in_ready at a clk edge
- dout  output  1  serial bit stream (downstream din)
- dout_valid  output  1  dout carries a data bit this cycle
- frame_start  output  1  dout is the first bit of a word
- frame_end  output  1  dout is the last bit of a word
- busy  output  1  a word is being shifted (equals dout_valid)

Behaviour:
- Reset (rst low, asynchronous):
  - dout = IDLE_BIT; dout_valid, frame_start, frame_end, busy = 0.
  - State = IDLE; bit counter = 0; shift register = 0.
  - in_ready = 0 while rst is low.
- Output timing:
  - All outputs except in_ready are registered.
  - in_ready is combinational from state and counter only; it never depends on in_valid.
- States:
  - IDLE: in_ready = 1, dout_valid = 0, dout = IDLE_BIT.
  - SHIFT: dout_valid = 1; the counter cnt (0..WIDTH-1, width clog2(WIDTH)) indexes the bit currently on dout.
- Transitions:
  - IDLE -> SHIFT on a transfer. On that edge the word is latched, the first bit is placed on dout, and cnt = 0.
  - SHIFT, cnt < WIDTH-1: each edge advances to the next bit and increments cnt. in_ready = 0.
  - SHIFT, cnt == WIDTH-1: in_ready = 1.
    - With a transfer: the new word's first bit appears on the next cycle, cnt = 0, and the state stays SHIFT. There is no idle bubble.
    - Without a transfer: return to IDLE; dout = IDLE_BIT on the next cycle.
- Latency: a word accepted at edge N has bit k on dout during cycle N+1+k.
- Bit order:
  - MSB_FIRST = 1: in_data[WIDTH-1] down to in_data[0].
  - MSB_FIRST = 0: in_data[0] up to in_data[WIDTH-1].
- Frame flags:
  - frame_start = 1 exactly when cnt == 0 in SHIFT.
  - frame_end = 1 exactly when cnt == WIDTH-1 in SHIFT.
  - Both are single-cycle per word.
- Input handling:
  - in_data and in_valid are ignored when in_ready = 0.
  - Changes to in_data after acceptance do not affect the word in flight.
  - Dropping in_valid mid-frame does not truncate the frame.
- Reset mid-frame: output returns to the reset values immediately (asynchronously); the partial word is discarded. After rst deasserts, the first word restarts at bit 0.
- No X on any output after reset, regardless of in_data contents.

Test Plan:
- Reset check: hold rst low 3 cycles with in_valid = 1 and in_data = 8'hFF -> dout = 0, dout_valid = 0, in_ready = 0; after release, in_ready = 1 and dout_valid stays 0 until a transfer.
- Single word, MSB_FIRST = 1: accept 8'hA5 at edge N -> dout = 1,0,1,0,0,1,0,1 in cycles N+1..N+8.
  - frame_start high only in N+1; frame_end high only in N+8.
  - dout = IDLE_BIT and dout_valid = 0 in N+9.
- Back-to-back: in_valid held with 8'hF0 then 8'h0F -> 16 contiguous valid bits 1111000000001111.
  - in_ready high only in the accept cycles, i.e. IDLE and cycle N+8.
  - frame_start pulses in N+1 and N+9.
- LSB_FIRST variant (MSB_FIRST = 0): accept 8'h01 -> dout = 1,0,0,0,0,0,0,0.
- Protocol robustness: change in_data and drop in_valid during bits 2..5 of 8'hC3 -> the serial output still equals 8'hC3 bit-exact, and no extra transfer occurs.
- Reset mid-frame: assert rst during bit 4 of 8'hFF -> dout = 0 and dout_valid = 0 the same cycle. After release, accept 8'h81 -> bits 1,0,0,0,0,0,0,1 with frame_start on the first bit.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in / serial-out front end. Accepts WIDTH-bit words over a
//   valid/ready handshake and shifts them out one bit per clock on dout,
//   with no idle bubble between back-to-back words.
//
// Parameters
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT  level driven on dout while no word is being shifted
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_data      parallel word to serialize
//   in_valid     in_data holds a valid word
//   in_ready     word accepted this cycle (combinational from state/counter)
//   dout         serial bit stream
//   dout_valid   dout carries a data bit
//   frame_start  dout is the first bit of a word
//   frame_end    dout is the last bit of a word
//   busy         a word is being shifted (same as dout_valid)
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             dout_q, dout_d;
   logic             vld_q, vld_d;
   logic             fs_q, fs_d;
   logic             fe_q, fe_d;
   logic             take;

   // Bit that leaves first from a word held in the shift register.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Drop the bit just placed on dout so the next one sits at the head.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   // Ready while idle, and on the last bit of a frame so the next word
   // follows with no gap. Forced low while reset is held.
   assign in_ready = rst & ((state_q == S_IDLE) | (cnt_q == LAST));
   assign take     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      dout_d  = IDLE_BIT;
      vld_d   = 1'b0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;

      if (state_q == S_SHIFT && cnt_q != LAST) begin
         state_d = S_SHIFT;
         cnt_d   = cnt_q + CW'(1);
         dout_d  = head_bit(shreg_q);
         shreg_d = advance(shreg_q);
         vld_d   = 1'b1;
         fe_d    = (cnt_q + CW'(1)) == LAST;
      end else if (take) begin
         // Load from IDLE or directly after the last bit of a frame:
         // first bit goes straight to dout, the rest waits in shreg.
         state_d = S_SHIFT;
         cnt_d   = '0;
         dout_d  = head_bit(in_data);
         shreg_d = advance(in_data);
         vld_d   = 1'b1;
         fs_d    = 1'b1;
      end else begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         dout_q  <= IDLE_BIT;
         vld_q   <= 1'b0;
         fs_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         fs_q    <= fs_d;
         fe_q    <= fe_d;
      end
   end

   assign dout        = dout_q;
   assign dout_valid  = vld_q;
   assign frame_start = fs_q;
   assign frame_end   = fe_q;
   assign busy        = vld_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready, dout, dout_valid, frame_start, frame_end, busy;

   logic [W-1:0] l_in_data = '0;
   logic         l_in_valid = 1'b0;
   logic         l_in_ready, l_dout, l_dout_valid, l_fs, l_fe, l_busy;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
      .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid),
      .in_ready(l_in_ready), .dout(l_dout), .dout_valid(l_dout_valid),
      .frame_start(l_fs), .frame_end(l_fe), .busy(l_busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;

   // Reference model: queue of bits still to appear on dout, each tagged
   // with its frame-start/frame-end role. A word is accepted only when no
   // bits are pending beyond the one currently shown.
   typedef struct packed {logic b; logic s; logic e;} rec_t;
   rec_t exp_q[$];
   rec_t cur;
   logic cur_v = 1'b0;
   logic [5:0] exp_v;
   logic [5:0] obs;
   assign obs = {dout, dout_valid, frame_start, frame_end, busy, in_ready};

   task automatic model_clear();
      exp_q.delete();
      cur_v = 1'b0;
      cur   = '0;
   endtask

   // Advance one clock; leaves expected outputs in exp_v, sampled 1ns later.
   task automatic step();
      logic         acc;
      logic [W-1:0] w;
      rec_t         r;
      acc = in_valid && rst && (exp_q.size() == 0);
      w   = in_data;
      @(posedge clk);
      if (acc) begin
         for (int k = 0; k < W; k++) begin
            r.b = w[W-1-k];
            r.s = (k == 0);
            r.e = (k == W-1);
            exp_q.push_back(r);
         end
         n_acc++;
      end
      cur_v = (exp_q.size() > 0);
      if (cur_v) cur = exp_q.pop_front();
      else       cur = '0;
      exp_v = {cur_v & cur.b, cur_v, cur_v & cur.s, cur_v & cur.e, cur_v,
               exp_q.size() == 0};
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d got %b want %b", i, obs, 6'b0);
         end
      end
      rst      = 1'b1;
      in_valid = 1'b0;
      model_clear();
      for (int i = 0; i < 2; i++) begin
         step();
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release cyc%0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_single();
      logic [W-1:0] bits = '0;
      in_data  = 8'hA5;
      in_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         in_valid = 1'b0;
         in_data  = W'($urandom);
         if (dout_valid) bits = {bits[W-2:0], dout};
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL single cyc%0d got %b want %b", i, obs, exp_v);
         end
      end
      n_tests++;
      if (bits !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_word got %h want %h", bits, 8'hA5);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] bits = '0;
      int start = n_acc;
      in_data  = 8'hF0;
      in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step();
         in_data  = (n_acc - start >= 1) ? 8'h0F : 8'hF0;
         in_valid = (n_acc - start < 2);
         if (dout_valid) bits = {bits[2*W-2:0], dout};
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL b2b cyc%0d got %b want %b", i, obs, exp_v);
         end
      end
      n_tests++;
      if (bits !== 16'hF00F) begin
         n_fail++;
         $display("FAIL b2b_stream got %h want %h", bits, 16'hF00F);
      end
   endtask

   task automatic test_robust();
      logic [W-1:0] bits = '0;
      int start = n_acc;
      in_data  = 8'hC3;
      in_valid = 1'b1;
      step();
      if (dout_valid) bits = {bits[W-2:0], dout};
      for (int i = 1; i <= 9; i++) begin
         if (i - 1 >= 2 && i - 1 <= 5) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (dout_valid) bits = {bits[W-2:0], dout};
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL robust cyc%0d got %b want %b", i, obs, exp_v);
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (bits !== 8'hC3 || n_acc - start != 1) begin
         n_fail++;
         $display("FAIL robust_word got %h/%0d xfers want %h/1", bits, n_acc - start, 8'hC3);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] bits = '0;
      in_data  = 8'hFF;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         in_valid = 1'b0;
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (dout !== 1'b0 || dout_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid got dout=%b vld=%b rdy=%b want 0/0/0", dout, dout_valid, in_ready);
      end
      model_clear();
      @(posedge clk); #1;
      rst      = 1'b1;
      in_data  = 8'h81;
      in_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         in_valid = 1'b0;
         if (dout_valid) bits = {bits[W-2:0], dout};
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL after_reset cyc%0d got %b want %b", i, obs, exp_v);
         end
      end
      n_tests++;
      if (bits !== 8'h81) begin
         n_fail++;
         $display("FAIL after_reset_word got %h want %h", bits, 8'h81);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = W'($urandom);
         step();
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL random cyc%0d got %b want %b", i, obs, exp_v);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < W + 1; i++) step();
   endtask

   task automatic test_lsb_first();
      logic [W-1:0] words [2];
      logic [W-1:0] w;
      words[0] = 8'h01;
      words[1] = W'($urandom);
      for (int n = 0; n < 2; n++) begin
         w = words[n];
         @(negedge clk);
         l_in_data  = w;
         l_in_valid = 1'b1;
         @(posedge clk); #1;
         l_in_valid = 1'b0;
         l_in_data  = ~w;
         for (int k = 0; k < W; k++) begin
            n_tests++;
            if ({l_dout, l_dout_valid, l_fs, l_fe} !== {w[k], 1'b1, k == 0, k == W-1}) begin
               n_fail++;
               $display("FAIL lsb w%0d bit%0d got %b%b%b%b want %b1%b%b", n, k,
                        l_dout, l_dout_valid, l_fs, l_fe, w[k], k == 0, k == W-1);
            end
            @(posedge clk); #1;
         end
         n_tests++;
         if ({l_dout, l_dout_valid, l_in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL lsb_idle w%0d got %b%b%b want 001", n, l_dout, l_dout_valid, l_in_ready);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_robust();
      test_reset_mid();
      test_random();
      test_lsb_first();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
